// File: rtl/ocp_mem_tester_pkg.sv
// Shared OCP encodings, bus widths and the write/read pattern for the memory tester.
package ocp_mem_tester_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned BEN_WIDTH  = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        OCP_CMD_IDLE  = 3'b000,
        OCP_CMD_WRITE = 3'b001,
        OCP_CMD_READ  = 3'b010
    } ocp_cmd_e;

    typedef enum logic [1:0] {
        OCP_RESP_NULL = 2'b00,
        OCP_RESP_DVA  = 2'b01,
        OCP_RESP_FAIL = 2'b10,
        OCP_RESP_ERR  = 2'b11
    } ocp_resp_e;

    // Command the tester FSM hands to the master port.
    typedef struct packed {
        ocp_cmd_e              cmd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } ocp_req_t;

    // Word data is its own byte address XOR the seed.
    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [DATA_WIDTH-1:0] seed);
        return DATA_WIDTH'(addr) ^ seed;
    endfunction

endpackage

// File: rtl/ocp_mem_tester_if.sv
// OCP word-memory bus between an initiator (master) and a responder (slave).
interface ocp_mem_tester_if;
    import ocp_mem_tester_pkg::*;

    logic [ADDR_WIDTH-1:0] MAddr;
    ocp_cmd_e              MCmd;
    logic [DATA_WIDTH-1:0] MData;
    logic [BEN_WIDTH-1:0]  MByteEn;
    logic                  SCmdAccept;
    logic [DATA_WIDTH-1:0] SData;
    ocp_resp_e             SResp;

    modport master (
        output MAddr, MCmd, MData, MByteEn,
        input  SCmdAccept, SData, SResp
    );

    modport slave (
        input  MAddr, MCmd, MData, MByteEn,
        output SCmdAccept, SData, SResp
    );

endinterface

// File: rtl/ocp_mem_tester_master_port.sv
// OCP master port: holds the issued command until accept, exposes the response
// and runs the no-progress timeout counter.
module ocp_mem_tester_master_port
    import ocp_mem_tester_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    ocp_mem_tester_if.master      ocp,
    input  logic                  ld,
    input  ocp_req_t              ld_req,
    input  logic                  active,
    input  logic                  progress,
    output logic                  accept_c,
    output logic                  resp_valid_c,
    output logic                  resp_ok_c,
    output logic [DATA_WIDTH-1:0] rdata_c,
    output logic                  timeout_c
);

    localparam int unsigned TMR_WIDTH = $clog2(TIMEOUT + 1);

    logic [TMR_WIDTH-1:0] tmr;

    // Address/data/byte-enables only move with a real command; MCmd qualifies them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ocp.MCmd    <= OCP_CMD_IDLE;
            ocp.MAddr   <= '0;
            ocp.MData   <= '0;
            ocp.MByteEn <= '0;
        end else if (ld) begin
            ocp.MCmd <= ld_req.cmd;
            if (ld_req.cmd != OCP_CMD_IDLE) begin
                ocp.MAddr   <= ld_req.addr;
                ocp.MData   <= ld_req.data;
                ocp.MByteEn <= '1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !active || progress) begin
            tmr <= '0;
        end else if (tmr != TMR_WIDTH'(TIMEOUT)) begin
            tmr <= tmr + TMR_WIDTH'(1);
        end
    end

    assign accept_c     = (ocp.MCmd != OCP_CMD_IDLE) && ocp.SCmdAccept;
    assign resp_valid_c = (ocp.SResp != OCP_RESP_NULL);
    assign resp_ok_c    = (ocp.SResp == OCP_RESP_DVA);
    assign rdata_c      = ocp.SData;
    assign timeout_c    = active && !progress && (tmr == TMR_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/ocp_mem_tester.sv
// OCP memory tester: writes addr^seed to N consecutive words, reads them back
// and reports pass, mismatch count, first failing address and timeout.
module ocp_mem_tester
    import ocp_mem_tester_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [CNT_WIDTH-1:0]  i_nwords,
    input  logic [DATA_WIDTH-1:0] i_seed,
    ocp_mem_tester_if.master      ocp,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic                  o_timeout,
    output logic [CNT_WIDTH-1:0]  o_err_count,
    output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_CMD,
        ST_RD_CMD,
        ST_RD_WAIT,
        ST_FINISH
    } state_e;

    state_e                state;
    logic [CNT_WIDTH-1:0]  k;
    logic [CNT_WIDTH-1:0]  nwords_r;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] seed_r;

    logic [ADDR_WIDTH-1:0] start_addr_c;
    logic [ADDR_WIDTH-1:0] next_addr_c;
    logic                  last_c;
    logic                  active_c;
    logic                  progress_c;
    logic                  rd_eval_c;
    logic                  mismatch_c;
    logic                  ld_c;
    ocp_req_t              ld_req_c;
    logic                  accept_c;
    logic                  resp_valid_c;
    logic                  resp_ok_c;
    logic [DATA_WIDTH-1:0] rdata_c;
    logic                  timeout_c;

    ocp_mem_tester_master_port #(.TIMEOUT(TIMEOUT)) u_port (
        .clk          (clk),
        .rst          (rst),
        .ocp          (ocp),
        .ld           (ld_c),
        .ld_req       (ld_req_c),
        .active       (active_c),
        .progress     (progress_c),
        .accept_c     (accept_c),
        .resp_valid_c (resp_valid_c),
        .resp_ok_c    (resp_ok_c),
        .rdata_c      (rdata_c),
        .timeout_c    (timeout_c)
    );

    assign start_addr_c = i_base_addr & ~ADDR_WIDTH'(3);
    assign next_addr_c  = cur_addr + ADDR_WIDTH'(4);
    assign last_c       = (k == nwords_r - CNT_WIDTH'(1));
    assign active_c     = state inside {ST_WR_CMD, ST_RD_CMD, ST_RD_WAIT};
    // A response landing with the read accept is evaluated there and never again in RD_WAIT.
    assign rd_eval_c    = ((state == ST_RD_CMD) && accept_c && resp_valid_c) ||
                          ((state == ST_RD_WAIT) && resp_valid_c);
    assign progress_c   = accept_c || ((state == ST_RD_WAIT) && resp_valid_c);
    assign mismatch_c   = !(resp_ok_c && (rdata_c == pattern(cur_addr, seed_r)));

    // Next command for the port, computed so back-to-back issue needs no bubble.
    always_comb begin
        ld_c          = 1'b0;
        ld_req_c.cmd  = OCP_CMD_IDLE;
        ld_req_c.addr = next_addr_c;
        ld_req_c.data = '0;
        case (state)
            ST_IDLE: begin
                if (i_start && (i_nwords != '0)) begin
                    ld_c          = 1'b1;
                    ld_req_c.cmd  = OCP_CMD_WRITE;
                    ld_req_c.addr = start_addr_c;
                    ld_req_c.data = pattern(start_addr_c, i_seed);
                end
            end
            ST_WR_CMD: begin
                if (accept_c) begin
                    ld_c = 1'b1;
                    if (last_c) begin
                        ld_req_c.cmd  = OCP_CMD_READ;
                        ld_req_c.addr = base_r;
                    end else begin
                        ld_req_c.cmd  = OCP_CMD_WRITE;
                        ld_req_c.data = pattern(next_addr_c, seed_r);
                    end
                end else if (timeout_c) begin
                    ld_c = 1'b1;
                end
            end
            ST_RD_CMD: begin
                if (accept_c) begin
                    ld_c = 1'b1;
                    if (resp_valid_c && !last_c) begin
                        ld_req_c.cmd = OCP_CMD_READ;
                    end
                end else if (timeout_c) begin
                    ld_c = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                if (resp_valid_c && !last_c) begin
                    ld_c         = 1'b1;
                    ld_req_c.cmd = OCP_CMD_READ;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            k                <= '0;
            nwords_r         <= '0;
            base_r           <= '0;
            cur_addr         <= '0;
            seed_r           <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_pass           <= 1'b0;
            o_timeout        <= 1'b0;
            o_err_count      <= '0;
            o_first_err_addr <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        base_r           <= start_addr_c;
                        cur_addr         <= start_addr_c;
                        seed_r           <= i_seed;
                        nwords_r         <= i_nwords;
                        k                <= '0;
                        o_err_count      <= '0;
                        o_first_err_addr <= '0;
                        o_pass           <= 1'b0;
                        o_timeout        <= 1'b0;
                        o_busy           <= 1'b1;
                        state            <= (i_nwords == '0) ? ST_FINISH : ST_WR_CMD;
                    end
                end
                ST_WR_CMD: begin
                    if (accept_c) begin
                        if (last_c) begin
                            k        <= '0;
                            cur_addr <= base_r;
                            state    <= ST_RD_CMD;
                        end else begin
                            k        <= k + CNT_WIDTH'(1);
                            cur_addr <= next_addr_c;
                        end
                    end else if (timeout_c) begin
                        o_timeout <= 1'b1;
                        state     <= ST_FINISH;
                    end
                end
                ST_RD_CMD: begin
                    if (accept_c && !resp_valid_c) begin
                        state <= ST_RD_WAIT;
                    end else if (timeout_c) begin
                        o_timeout <= 1'b1;
                        state     <= ST_FINISH;
                    end
                end
                ST_RD_WAIT: begin
                    if (timeout_c) begin
                        o_timeout <= 1'b1;
                        state     <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    o_pass <= (o_err_count == '0) && !o_timeout;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (rd_eval_c) begin
                if (mismatch_c) begin
                    if (o_err_count != '1) begin
                        o_err_count <= o_err_count + CNT_WIDTH'(1);
                    end
                    if (o_err_count == '0) begin
                        o_first_err_addr <= cur_addr;
                    end
                end
                if (last_c) begin
                    state <= ST_FINISH;
                end else begin
                    k        <= k + CNT_WIDTH'(1);
                    cur_addr <= next_addr_c;
                    state    <= ST_RD_CMD;
                end
            end
        end
    end

endmodule

// File: tb/tb_ocp_mem_tester.sv
// Directed bench for ocp_mem_tester against a configurable word-memory responder.
module tb_ocp_mem_tester;
    import ocp_mem_tester_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [15:0] i_nwords = '0;
    logic [31:0] i_seed = '0;
    logic        o_busy, o_done, o_pass, o_timeout;
    logic [15:0] o_err_count;
    logic [31:0] o_first_err_addr;

    ocp_mem_tester_if bus ();

    ocp_mem_tester #(.CNT_WIDTH(16), .TIMEOUT(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_start          (i_start),
        .i_base_addr      (i_base_addr),
        .i_nwords         (i_nwords),
        .i_seed           (i_seed),
        .ocp              (bus),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_pass           (o_pass),
        .o_timeout        (o_timeout),
        .o_err_count      (o_err_count),
        .o_first_err_addr (o_first_err_addr)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          stall_n = 0, lat = 0, no_resp = 0, corrupt = 0;
    logic [31:0] corrupt_addr = '0;
    logic [31:0] mem [0:15];
    logic [31:0] wr_addr [0:15];
    logic [31:0] wr_data [0:15];
    int          wr_cnt = 0, rd_cnt = 0, stall_cnt = 0, unstable = 0;

    // Responder: decides accept/response at negedge for the following posedge.
    initial begin : responder
        logic [31:0] rdata;
        logic        pend;
        logic [31:0] pend_data;
        ocp_cmd_e    last_cmd;
        logic [31:0] last_addr, last_data;
        pend = 1'b0;
        pend_data = '0;
        last_cmd = OCP_CMD_IDLE;
        last_addr = '0;
        last_data = '0;
        bus.SCmdAccept = 1'b0;
        bus.SResp = OCP_RESP_NULL;
        bus.SData = '0;
        forever begin
            @(negedge clk);
            bus.SCmdAccept = 1'b0;
            bus.SResp = OCP_RESP_NULL;
            if (pend) begin
                bus.SResp = OCP_RESP_DVA;
                bus.SData = pend_data;
                pend = 1'b0;
            end
            if (bus.MCmd != OCP_CMD_IDLE) begin
                if (stall_cnt > 0 && (bus.MCmd !== last_cmd || bus.MAddr !== last_addr ||
                                      bus.MData !== last_data))
                    unstable++;
                last_cmd = bus.MCmd;
                last_addr = bus.MAddr;
                last_data = bus.MData;
                if (stall_cnt < stall_n) begin
                    stall_cnt++;
                end else begin
                    stall_cnt = 0;
                    bus.SCmdAccept = 1'b1;
                    if (bus.MCmd == OCP_CMD_WRITE) begin
                        if (wr_cnt < 16) begin
                            wr_addr[wr_cnt] = bus.MAddr;
                            wr_data[wr_cnt] = bus.MData;
                        end
                        wr_cnt++;
                        mem[bus.MAddr[5:2]] = bus.MData;
                    end else begin
                        rd_cnt++;
                        rdata = mem[bus.MAddr[5:2]] ^
                                ((corrupt != 0 && bus.MAddr == corrupt_addr) ? 32'd1 : 32'd0);
                        if (no_resp == 0) begin
                            if (lat == 0) begin
                                bus.SResp = OCP_RESP_DVA;
                                bus.SData = rdata;
                            end else begin
                                pend = 1'b1;
                                pend_data = rdata;
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raise start for the edge that samples it; returns 1 ns after that edge.
    task automatic start_test(input logic [31:0] base, input logic [15:0] n, input logic [31:0] seed);
        wr_cnt = 0;
        rd_cnt = 0;
        stall_cnt = 0;
        @(negedge clk);
        i_base_addr = base;
        i_nwords = n;
        i_seed = seed;
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int maxc, output int ncyc);
        ncyc = 0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            ncyc++;
            if (o_done) break;
        end
        chk({tag, "_done"}, 32'(o_done), 32'd1);
    endtask

    task automatic wait_read_accept(input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (rd_cnt >= 1) begin
                seen = 1;
                break;
            end
        end
        chk({tag, "_rd_accept"}, 32'(seen), 32'd1);
    endtask

    initial begin : stimulus
        int ncyc;
        int seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mcmd", 32'(bus.MCmd), 32'(OCP_CMD_IDLE));
        chk("rst_maddr", bus.MAddr, 32'd0);
        chk("rst_mdata", bus.MData, 32'd0);
        chk("rst_mbyteen", 32'(bus.MByteEn), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_pass", 32'(o_pass), 32'd0);
        chk("rst_timeout", 32'(o_timeout), 32'd0);
        chk("rst_errcnt", 32'(o_err_count), 32'd0);
        chk("rst_firsterr", o_first_err_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic pass, zero-latency responder (response with the read accept).
        start_test(32'h0, 16'd4, 32'hdeadbeef);
        wait_done("basic", 100, ncyc);
        chk("basic_pass", 32'(o_pass), 32'd1);
        chk("basic_errcnt", 32'(o_err_count), 32'd0);
        chk("basic_firsterr", o_first_err_addr, 32'd0);
        chk("basic_timeout", 32'(o_timeout), 32'd0);
        chk("basic_busy", 32'(o_busy), 32'd0);
        chk("basic_wr_cnt", 32'(wr_cnt), 32'd4);
        chk("basic_rd_cnt", 32'(rd_cnt), 32'd4);
        chk("basic_wd0", wr_data[0], 32'hdeadbeef);
        chk("basic_wd1", wr_data[1], 32'hdeadbeeb);
        chk("basic_wd2", wr_data[2], 32'hdeadbee7);
        chk("basic_wd3", wr_data[3], 32'hdeadbee3);
        chk("basic_wa3", wr_addr[3], 32'h0000000c);
        chk("basic_mbyteen", 32'(bus.MByteEn), 32'h0000000f);
        @(posedge clk);
        #1;
        chk("basic_done_pulse", 32'(o_done), 32'd0);

        // Backpressure: 3 stall cycles per command, read data one cycle after accept.
        stall_n = 3;
        lat = 1;
        unstable = 0;
        start_test(32'h0, 16'd4, 32'hdeadbeef);
        wait_done("bp", 300, ncyc);
        chk("bp_pass", 32'(o_pass), 32'd1);
        chk("bp_errcnt", 32'(o_err_count), 32'd0);
        chk("bp_wd1", wr_data[1], 32'hdeadbeeb);
        chk("bp_wd2", wr_data[2], 32'hdeadbee7);
        chk("bp_stable", 32'(unstable), 32'd0);
        chk("bp_rd_cnt", 32'(rd_cnt), 32'd4);
        stall_n = 0;
        lat = 0;

        // Corruption of the word at byte address 8.
        corrupt = 1;
        corrupt_addr = 32'h8;
        start_test(32'h0, 16'd4, 32'hdeadbeef);
        wait_done("corrupt", 100, ncyc);
        chk("corrupt_errcnt", 32'(o_err_count), 32'd1);
        chk("corrupt_firsterr", o_first_err_addr, 32'h8);
        chk("corrupt_pass", 32'(o_pass), 32'd0);
        chk("corrupt_timeout", 32'(o_timeout), 32'd0);
        corrupt = 0;

        // Wrap-around from the top word; low address bits ignored.
        start_test(32'hffffffff, 16'd2, 32'h12345678);
        wait_done("wrap", 100, ncyc);
        chk("wrap_wa0", wr_addr[0], 32'hfffffffc);
        chk("wrap_wd0", wr_data[0], 32'hedcba984);
        chk("wrap_wa1", wr_addr[1], 32'h00000000);
        chk("wrap_wd1", wr_data[1], 32'h12345678);
        chk("wrap_pass", 32'(o_pass), 32'd1);
        chk("wrap_rd_cnt", 32'(rd_cnt), 32'd2);

        // Zero words: done two cycles after the start cycle, no bus traffic.
        start_test(32'h40, 16'd0, 32'h1);
        chk("n0_busy", 32'(o_busy), 32'd1);
        wait_done("n0", 10, ncyc);
        chk("n0_latency", 32'(1 + ncyc), 32'd2);
        chk("n0_pass", 32'(o_pass), 32'd1);
        chk("n0_wr_cnt", 32'(wr_cnt), 32'd0);
        chk("n0_rd_cnt", 32'(rd_cnt), 32'd0);
        chk("n0_mcmd", 32'(bus.MCmd), 32'(OCP_CMD_IDLE));

        // Timeout: read accepted but never answered.
        no_resp = 1;
        start_test(32'h0, 16'd4, 32'hdeadbeef);
        wait_read_accept("to");
        #1;
        wait_done("to", 40, ncyc);
        chk("to_latency", 32'(ncyc), 32'd17);
        chk("to_timeout", 32'(o_timeout), 32'd1);
        chk("to_pass", 32'(o_pass), 32'd0);
        chk("to_errcnt", 32'(o_err_count), 32'd0);
        chk("to_mcmd", 32'(bus.MCmd), 32'(OCP_CMD_IDLE));
        chk("to_rd_cnt", 32'(rd_cnt), 32'd1);

        // Reset while waiting for a read response, then restart.
        start_test(32'h20, 16'd4, 32'ha5a5a5a5);
        wait_read_accept("mrst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_mcmd", 32'(bus.MCmd), 32'(OCP_CMD_IDLE));
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_done", 32'(o_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (o_done) seen = 1;
        end
        chk("mrst_no_done", 32'(seen), 32'd0);
        no_resp = 0;
        start_test(32'h20, 16'd4, 32'ha5a5a5a5);
        wait_done("restart", 100, ncyc);
        chk("restart_pass", 32'(o_pass), 32'd1);
        chk("restart_errcnt", 32'(o_err_count), 32'd0);
        chk("restart_rd_cnt", 32'(rd_cnt), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ocp_mem_tester.md
Name: ocp_mem_tester

Overview:
- OCP initiator (master) that exercises any OCP word-memory responder, e.g. `memory`.
- On start it writes a deterministic pattern to N consecutive words, then reads them back and compares.
- Reports pass/fail, mismatch count, first failing address, and timeout.
- Used as a self-checking traffic source in system benches and FPGA bring-up.

Parameters:
- ADDR_WIDTH, `ADDR_WIDTH (32): OCP address width.
- DATA_WIDTH, `DATA_WIDTH (32): OCP data width.
- BEN_WIDTH, `BEN_WIDTH (4): byte-enable width, equal to DATA_WIDTH/8.
- CNT_WIDTH, 16: width of word count and error counter.
- TIMEOUT, 256: maximum cycles to wait for an accept or a read response before aborting.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  start pulse; ignored while o_busy=1.
- i_base_addr  in  ADDR_WIDTH  first byte address; bits [1:0] are ignored (treated as 0).
- i_nwords  in  CNT_WIDTH  number of words to test.
- i_seed  in  DATA_WIDTH  pattern seed.
- o_MAddr  out  ADDR_WIDTH  OCP address.
- o_MCmd  out  3  OCP command (IDLE/WRITE/READ).
- o_MData  out  DATA_WIDTH  write data.
- o_MByteEn  out  BEN_WIDTH  byte enables.
- i_SCmdAccept  in  1  responder accepts the current command.
- i_SData  in  DATA_WIDTH  read data.
- i_SResp  in  2  OCP response.
- o_busy  out  1  test in progress.
- o_done  out  1  one-cycle pulse at test end.
- o_pass  out  1  last test passed; valid from o_done until the next start.
- o_timeout  out  1  last test aborted on timeout.
- o_err_count  out  CNT_WIDTH  number of mismatches; saturates at all-ones.
- o_first_err_addr  out  ADDR_WIDTH  byte address of the first mismatch; 0 if there was none.

Behaviour:
- Reset (rst=1 at posedge):
  - State goes to IDLE.
  - o_MCmd=IDLE; o_MAddr, o_MData, o_MByteEn = 0.
  - o_busy, o_done, o_pass, o_timeout = 0; o_err_count = 0; o_first_err_addr = 0.
  - Reset mid-test aborts immediately. No o_done is produced and the bus is IDLE in the next cycle.
- Pattern:
  - Word k is at address A_k = base + 4k, with wrap-around modulo 2^ADDR_WIDTH.
  - Data D_k = A_k XOR i_seed (zero-extended/truncated to DATA_WIDTH).
  - base and seed are latched when the start is taken.
- States: IDLE, WR_CMD, RD_CMD, RD_WAIT, FINISH.
  - IDLE, i_start=1:
    - Latch inputs and clear err_count, first_err_addr, pass and timeout.
    - Set o_busy=1.
    - Go to WR_CMD, or to FINISH if i_nwords=0.
  - WR_CMD:
    - Drive MCmd=WRITE, MAddr=A_k, MData=D_k, MByteEn=all ones. Hold all signals stable until i_SCmdAccept=1 at a posedge.
    - On accept with k=N-1: go to RD_CMD with k=0. Otherwise k+1, and the next command is issued back-to-back in the following cycle.
    - Writes are posted; i_SResp is ignored in WR_CMD.
  - RD_CMD:
    - Drive MCmd=READ, MAddr=A_k, MByteEn=all ones, MData=0. Hold until accept.
    - On accept, if i_SResp!=NULL in the same cycle, evaluate it immediately; otherwise go to RD_WAIT with MCmd=IDLE.
  - RD_WAIT:
    - MCmd=IDLE; wait for i_SResp!=NULL.
    - Response evaluation:
      - SResp=DVA and i_SData==D_k: match.
      - Data differs, or SResp is FAIL/ERR: mismatch. err_count increments (saturating); on the first mismatch, first_err_addr=A_k.
    - After evaluating: if k=N-1 go to FINISH, else k+1 and go to RD_CMD.
  - FINISH:
    - One cycle: o_done=1, o_busy=0, o_pass=(err_count==0 && !timeout).
    - Then go to IDLE; the result outputs hold their values.
- Timeout:
  - A counter resets on entry to, and on every accept in, WR_CMD, RD_CMD and RD_WAIT.
  - If TIMEOUT cycles elapse without progress: o_timeout=1, MCmd=IDLE, go to FINISH (pass=0).
- Simultaneous events:
  - i_start in the FINISH cycle is ignored.
  - A response arriving in the same cycle as the read accept is consumed exactly once.
- Bus hygiene:
  - MCmd is IDLE in IDLE, RD_WAIT and FINISH.
  - MAddr/MData hold their last value when idle; only MCmd qualifies them.

Decomposition:
- Shared package/header ocp_const.vh holds OCP_CMD_IDLE/WRITE/READ and OCP_RESP_NULL/DVA/FAIL/ERR.
- common.vh holds ADDR/DATA/BEN widths.
- State encodings stay local to the module.
- One natural sub-module: ocp_master_port. It holds the command signals until accept, performs response capture, and runs the timeout counter. The tester FSM sits on top.

Test Plan:
- Basic pass: base=0, N=4, seed=32'hdeadbeef, zero-latency responder. Expect writes of deadbeef, deadbeeb, deadbee7, deadbee3 at 0, 4, 8, C; 4 reads; o_done pulse with pass=1 and err_count=0.
- Backpressure: responder deasserts SCmdAccept for 3 cycles per command. Commands are held stable across the stall, and the test still passes with the same data.
- Corruption: responder flips bit 0 of the read at address 8. Expect err_count=1, first_err_addr=8, pass=0.
- Timeout: responder never returns SResp for a read (TIMEOUT=16). Expect o_timeout=1, pass=0, o_done within 17 cycles of the read accept.
- Edge cases:
  - N=0 gives o_done 2 cycles after start, pass=1, and no bus commands.
  - base=32'hFFFFFFFC, N=2 wraps the second word to address 0.
- Reset mid-read: assert rst during RD_WAIT. Next cycle shows MCmd=IDLE, busy=0, no done pulse; a restart then passes.
